hssaer_tx_arbiter: RTL
======================

# hssaer_tx_arbiter

Round-robin arbiter that merges NCH parallel AER event sources onto the single HSSAER serial transmitter. It sits directly in front of hssaer_paer_tx and tags every granted event with its channel index in the MSBs. A registered output stage presents the merged event to the transmitter's src_rdy/dst_rdy handshake. An optional idle-timer drives the transmitter's keepalive input.

## Interface
- DSIZE, 8: width of merged event toward the transmitter
- IDW, 2: channel-tag width; NCH ≤ 2^IDW required
- NCH, 4: number of requesting channels (≥ 2)
- KA_PERIOD, 1024: idle cycles before a keepalive pulse (≥ 2)

- clkp  in  1  clock, all logic on rising edge
- _rst  in  1  reset, asynchronous, active-low
- ch_ae  in  NCH*(DSIZE-IDW)  channel events; channel i at bits [i*CW +: CW], CW = DSIZE-IDW
- ch_src_rdy  in  NCH  channel i has a valid event
- ch_dst_rdy  out  NCH  channel i event accepted this edge
- ch_en  in  NCH  channel enable mask; disabled channels are never granted
- tx_ae  out  DSIZE  merged event {tag, payload}
- tx_src_rdy  out  1  tx_ae valid
- tx_dst_rdy  in  1  transmitter ready (hssaer_paer_tx dst_rdy)
- keepalive  out  1  one-cycle keepalive request to the transmitter
- grant_id  out  IDW  tag of the last loaded channel (status)

## Operation
- Transfer rule, both sides: a transfer happens at a rising clkp edge where src_rdy and dst_rdy are both high. Sources hold data and src_rdy until accepted.
- Output register state is EMPTY (tx_src_rdy=0) or FULL (tx_src_rdy=1).
- EMPTY:
  - The combinational grant picks the first channel with ch_src_rdy & ch_en, scanning from rr_ptr upward and wrapping NCH-1→0.
  - ch_dst_rdy is one-hot on that channel, all zero if none.
  - At the edge: tx_ae ← {tag, payload}, grant_id ← tag, rr_ptr ← tag+1 (wraps to 0 after NCH-1), go to FULL.
- FULL:
  - All ch_dst_rdy = 0.
  - At an edge with tx_dst_rdy=1, go to EMPTY; tx_ae holds its value.
- No bypass: after a drain, the next load happens one edge later. Peak throughput is 1 event / 2 cycles, well above the serial rate.
- ch_en deasserting on a pending channel is honoured immediately; an event already loaded is still sent.
- Payload bits pass unmodified; the tag occupies tx_ae[DSIZE-1:DSIZE-IDW].

## Timing
- Reset values: tx_src_rdy=0, tx_ae=0, grant_id=0, rr_ptr=0, keepalive=0, ka counter=0, ch_dst_rdy=0.
- Latency: ch_src_rdy high in EMPTY → ch_dst_rdy in the same cycle → tx_src_rdy high after the next edge.
- Simultaneous requests: exactly one grant per load. With all channels requesting continuously, channel i is served once every NCH loads.
- Reset mid-operation: a pending FULL event is discarded, with no partial handshake.
- ch_dst_rdy depends only on registered state and inputs, so no combinational path exists from tx_dst_rdy to ch_dst_rdy.

## Configuration
- HSSAER_TXARB_KEEPALIVE_EN defined:
  - A counter of width ceil(log2 KA_PERIOD) increments each cycle while EMPTY with no grant.
  - It clears on any load.
  - On reaching KA_PERIOD-1, keepalive pulses high for one cycle and the counter clears.
- HSSAER_TXARB_KEEPALIVE_EN undefined: keepalive is tied to 0 and the counter is absent.

## Structure
- Shared package hssaer_pkg: default DSIZE/IDW constants, tag-field position constants, KA_PERIOD default.
- One sub-module, hssaer_rr_pick: combinational rotate-priority picker (req, en, ptr → onehot, idx, any).
- Top level holds the output register, rr_ptr, and the keepalive timer.

## Test plan
- Single channel: ch2 sends payload 6'h15, tx_dst_rdy=1 → one cycle later tx_ae=8'h95, tx_src_rdy=1; drained the next edge.
- All 4 channels hold src_rdy, tx_dst_rdy=1 → tags appear in order 0,1,2,3,0,… one event per 2 cycles.
- tx_dst_rdy held low for 10 cycles with requests pending → tx_ae stable, all ch_dst_rdy=0, nothing lost after release.
- ch_en=4'b1011 with all requesting → tag order 0,1,3,0,1,3.
- Macro on, KA_PERIOD=16, no traffic → keepalive pulses every 16 cycles; a load at cycle 10 defers the next pulse to 16 cycles after that load.
- Assert _rst while FULL → all outputs return to reset values immediately; ch0 event after release is tagged 0 and rr_ptr restarts at 0.

Source files
------------

// File: rtl/hssaer_pkg.sv
// hssaer_pkg: constants and types shared by the HSSAER transmit-side arbiter.
//   HSSAER_DSIZE / HSSAER_IDW / HSSAER_NCH / HSSAER_KA_PERIOD : defaults
//   HSSAER_TAG_MSB / HSSAER_TAG_LSB : position of the channel tag in tx_ae
//   out_state_t : output register state (EMPTY / FULL)
//   next_ptr()  : round-robin pointer advance with wrap at nch-1
package hssaer_pkg;

  localparam int HSSAER_DSIZE     = 8;
  localparam int HSSAER_IDW       = 2;
  localparam int HSSAER_NCH       = 4;
  localparam int HSSAER_KA_PERIOD = 1024;

  // The tag sits in the MSBs of the merged event; payload fills the rest.
  localparam int HSSAER_TAG_MSB = HSSAER_DSIZE - 1;
  localparam int HSSAER_TAG_LSB = HSSAER_DSIZE - HSSAER_IDW;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Next search start after serving channel idx.
  function automatic int next_ptr(input int idx, input int nch);
    return (idx == nch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/hssaer_rr_pick.sv
// hssaer_rr_pick: combinational rotate-priority picker.
// Scans channels starting at ptr, upward, wrapping NCH-1 -> 0, and returns the
// first channel whose req and en are both high.
//   req    in  NCH  request vector
//   en     in  NCH  enable mask (disabled channels never win)
//   ptr    in  IDW  first channel to consider (must be < NCH)
//   onehot out NCH  one-hot winner, all zero if none
//   idx    out IDW  binary winner index, 0 if none
//   any    out 1    a winner exists
module hssaer_rr_pick #(
  parameter int NCH = 4,
  parameter int IDW = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] en,
  input  logic [IDW-1:0] ptr,
  output logic [NCH-1:0] onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] c;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = '0;
    c      = '0;
    for (int k = 0; k < NCH; k++) begin
      // One extra bit holds ptr+k before the wrap back into 0..NCH-1.
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NCH)) sum = sum - (IDW+1)'(NCH);
      c = sum[IDW-1:0];
      if (!any && req[c] && en[c]) begin
        any       = 1'b1;
        onehot[c] = 1'b1;
        idx       = c;
      end
    end
  end

endmodule

// File: rtl/hssaer_tx_arbiter.sv
// hssaer_tx_arbiter: round-robin merge of NCH AER sources onto one HSSAER
// serial transmitter. Each granted event is tagged with its channel index in
// the MSBs and held in a one-entry output register.
//
// Handshake (both sides): a transfer happens at a rising clkp edge where
// src_rdy and dst_rdy are both high; a source holds data and src_rdy until
// accepted. The output register is EMPTY (tx_src_rdy=0) or FULL
// (tx_src_rdy=1); a load only happens from EMPTY, so ch_dst_rdy never depends
// combinationally on tx_dst_rdy. tx_src_rdy is the registered FSM state.
//
// Optional feature macro: HSSAER_TXARB_KEEPALIVE_EN enables the idle timer
// that pulses keepalive after KA_PERIOD idle cycles; otherwise keepalive = 0.
//
// Ports:
//   clkp        in  1               clock, rising edge
//   _rst        in  1               asynchronous active-low reset
//   ch_ae       in  NCH*(DSIZE-IDW) channel payloads, channel i at [i*CW +: CW]
//   ch_src_rdy  in  NCH             channel event valid
//   ch_dst_rdy  out NCH             channel event accepted this edge
//   ch_en       in  NCH             channel enable mask
//   tx_ae       out DSIZE           merged event {tag, payload}
//   tx_src_rdy  out 1               tx_ae valid
//   tx_dst_rdy  in  1               transmitter ready
//   keepalive   out 1               one-cycle keepalive request
//   grant_id    out IDW             tag of the last loaded channel
module hssaer_tx_arbiter
  import hssaer_pkg::*;
#(
  parameter int DSIZE     = HSSAER_DSIZE,
  parameter int IDW       = HSSAER_IDW,
  parameter int NCH       = HSSAER_NCH,
  parameter int KA_PERIOD = HSSAER_KA_PERIOD
) (
  input  logic                       clkp,
  input  logic                       _rst,
  input  logic [NCH*(DSIZE-IDW)-1:0] ch_ae,
  input  logic [NCH-1:0]             ch_src_rdy,
  output logic [NCH-1:0]             ch_dst_rdy,
  input  logic [NCH-1:0]             ch_en,
  output logic [DSIZE-1:0]           tx_ae,
  output logic                       tx_src_rdy,
  input  logic                       tx_dst_rdy,
  output logic                       keepalive,
  output logic [IDW-1:0]             grant_id
);

  localparam int CW = DSIZE - IDW;

  if (NCH < 2 || NCH > (1 << IDW) || KA_PERIOD < 2 || DSIZE <= IDW) begin : g_bad_cfg
    $error("hssaer_tx_arbiter: illegal parameter combination");
  end

  out_state_t     state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] pick_idx;
  logic [NCH-1:0] pick_onehot;
  logic           pick_any;
  logic           load;

  hssaer_rr_pick #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_pick (
    .req    (ch_src_rdy),
    .en     (ch_en),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clkp or negedge _rst) begin
    if (!_rst) state <= OUT_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ch_dst_rdy = '0;
    load       = 1'b0;
    case (state)
      OUT_EMPTY: begin
        // Acknowledge is suppressed while reset is asserted so no source sees
        // a handshake that the register will not capture.
        if (pick_any && _rst) begin
          ch_dst_rdy = pick_onehot;
          load       = 1'b1;
          state_nxt  = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (tx_dst_rdy) state_nxt = OUT_EMPTY;
      end
      default: state_nxt = OUT_EMPTY;
    endcase
  end

  assign tx_src_rdy = (state == OUT_FULL);

  always_ff @(posedge clkp or negedge _rst) begin
    if (!_rst) begin
      tx_ae    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      tx_ae    <= {pick_idx, ch_ae[int'(pick_idx)*CW +: CW]};
      grant_id <= pick_idx;
      rr_ptr   <= IDW'(next_ptr(int'(pick_idx), NCH));
    end
  end

`ifdef HSSAER_TXARB_KEEPALIVE_EN
  localparam int KAW = $clog2(KA_PERIOD);

  logic [KAW-1:0] ka_cnt;
  logic           ka_pulse;

  // Counts only idle EMPTY cycles; holds while FULL, clears on any load.
  always_ff @(posedge clkp or negedge _rst) begin
    if (!_rst) begin
      ka_cnt   <= '0;
      ka_pulse <= 1'b0;
    end else begin
      ka_pulse <= 1'b0;
      if (load) begin
        ka_cnt <= '0;
      end else if (state == OUT_EMPTY) begin
        if (ka_cnt == KAW'(KA_PERIOD - 1)) begin
          ka_cnt   <= '0;
          ka_pulse <= 1'b1;
        end else begin
          ka_cnt <= ka_cnt + 1'b1;
        end
      end
    end
  end

  assign keepalive = ka_pulse;
`else
  assign keepalive = 1'b0;
`endif

endmodule
